// File: rtl/seg7_scan_driver.sv
// Captures a 14-bit value, converts it to 4 BCD digits (double-dabble) and scans them onto a common-anode 7-segment bank.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [6:0]  seg7,
    output logic [3:0]  an
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nx;
    logic [13:0] sr, sr_nx;
    logic [15:0] bcd, bcd_nx, bcd_adj;
    logic [3:0]  iter, iter_nx;
    logic [15:0] digits, digits_nx;
    logic        ovf, ovf_nx;
    logic [29:0] shifted;

    logic [CW-1:0] rcnt;
    logic [1:0]    idx;
    logic [3:0]    cur_digit;
    logic          blank;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            bcd    <= '0;
            iter   <= '0;
            digits <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nx;
            sr     <= sr_nx;
            bcd    <= bcd_nx;
            iter   <= iter_nx;
            digits <= digits_nx;
            ovf    <= ovf_nx;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            bcd_adj[n*4 +: 4] = (bcd[n*4 +: 4] >= 4'd5) ? bcd[n*4 +: 4] + 4'd3 : bcd[n*4 +: 4];
        end
        shifted = {bcd_adj, sr} << 1;
    end

    always_comb begin
        state_nx  = state;
        sr_nx     = sr;
        bcd_nx    = bcd;
        iter_nx   = iter;
        digits_nx = digits;
        ovf_nx    = ovf;
        case (state)
            IDLE: begin
                if (load) begin
                    if (value > 14'd9999) begin
                        ovf_nx = 1'b1;
                    end else begin
                        sr_nx    = value;
                        bcd_nx   = '0;
                        iter_nx  = '0;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                bcd_nx  = shifted[29:14];
                sr_nx   = shifted[13:0];
                iter_nx = iter + 4'd1;
                // Final iteration commits the shifted result straight into the display digits.
                if (iter == 4'd13) begin
                    digits_nx = shifted[29:14];
                    ovf_nx    = 1'b0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    assign cur_digit = digits[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [15:0] upper;
    assign upper = digits >> {idx, 2'b00};
    assign blank = !ovf && (idx != 2'd0) && (upper == '0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_nx = decode(cur_digit);
        if (ovf)
            seg_nx = 7'b0111111;
        else if (blank)
            seg_nx = 7'b1111111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an   <= '1;
            seg7 <= '1;
        end else begin
            an   <= ~(4'b0001 << idx);
            seg7 <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: arithmetic reference model checked every cycle plus directed literal checks.
module tb_seg7_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic [6:0]  seg7;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;

    logic [6:0] code [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int p10 [0:3] = '{1, 10, 100, 1000};
    logic [6:0] dash = 7'b0111111;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [6:0] zlead = 7'b1111111;
`else
    logic [6:0] zlead = 7'b1000000;
`endif

    seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy), .seg7(seg7), .an(an)
    );

    always #5 clk = ~clk;

    // Reference model: displayed number as an integer, busy as a countdown of remaining cycles.
    bit         mvalid = 1'b0;
    int         m_val = 0, m_pend = 0, m_left = 0, m_tick = 0;
    bit         m_ovf = 1'b0;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_busy;

    function automatic logic [6:0] exp_digit(input int val, input bit ovf, input int i);
        if (ovf) return 7'b0111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i > 0 && val < p10[i]) return 7'b1111111;
`endif
        return code[(val / p10[i]) % 10];
    endfunction

    always @(posedge clk) begin
        int i;
        if (rst) begin
            mvalid = 1'b1;
            m_val = 0; m_ovf = 1'b0; m_left = 0; m_tick = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_busy = 1'b0;
        end else if (mvalid) begin
            i = (m_tick / DIV) % 4;
            e_an = ~(4'b0001 << i);
            e_seg = exp_digit(m_val, m_ovf, i);
            m_tick++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val = m_pend;
                    m_ovf = 1'b0;
                end
            end else if (load) begin
                if (value > 9999) m_ovf = 1'b1;
                else begin
                    m_pend = value;
                    m_left = 14;
                end
            end
            e_busy = (m_left > 0);
        end
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_busy", {6'b0, busy}, {6'b0, e_busy});
            chk("model_an", {3'b0, an}, {3'b0, e_an});
            chk("model_seg7", seg7, e_seg);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        value = 14'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] seen;
        seen = '0;
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin chk({nm, "_d0"}, seg7, s0); seen[0] = 1'b1; end
                4'b1101: begin chk({nm, "_d1"}, seg7, s1); seen[1] = 1'b1; end
                4'b1011: begin chk({nm, "_d2"}, seg7, s2); seen[2] = 1'b1; end
                4'b0111: begin chk({nm, "_d3"}, seg7, s3); seen[3] = 1'b1; end
                default: chk({nm, "_an"}, {3'b0, an}, 7'b0001110);
            endcase
        end
        chk({nm, "_all_anodes"}, {3'b0, seen}, 7'b0001111);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_an", {3'b0, an}, 7'b0001110);
        chk("reset_seg7", seg7, 7'b1000000);
        chk("reset_busy", {6'b0, busy}, 7'b0);

        do_load(1234);
        busy_len(n);
        chk("busy_len_1234", 7'(n), 7'd14);
        chk_frame("f1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        do_load(10000);
        @(negedge clk);
        chk("ovf_busy_t1", {6'b0, busy}, 7'b0);
        @(negedge clk);
        chk("ovf_dash_t2", seg7, dash);
        chk_frame("f10000", dash, dash, dash, dash);
        do_load(16383);
        @(negedge clk);
        chk("ovf2_busy", {6'b0, busy}, 7'b0);
        chk_frame("f16383", dash, dash, dash, dash);

        do_load(42);
        repeat (4) tick();
        load = 1'b1;
        value = 14'd9999;
        tick();
        load = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        chk("lwb_busy_t15", {6'b0, busy}, 7'b0);
        chk_frame("f0042", 7'b0100100, 7'b0011001, zlead, zlead);

        do_load(7);
        busy_len(n);
        chk("busy_len_7", 7'(n), 7'd14);
        chk_frame("f7", 7'b1111000, zlead, zlead, zlead);

        do_load(5555);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_mid_busy", {6'b0, busy}, 7'b0);
        chk("rst_mid_an", {3'b0, an}, 7'b0001111);
        rst = 1'b0;
        tick();
        chk_frame("f_after_rst", 7'b1000000, zlead, zlead, zlead);
        do_load(5555);
        busy_len(n);
        chk("busy_len_5555", 7'(n), 7'd14);
        chk_frame("f5555", 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010);

        for (int k = 0; k < 1500; k++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 5) == 0);
            value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(10000, 16383))
                                                : 14'($urandom_range(0, 9999));
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
